// File: rtl/fft_pkg.sv
// Shared state type, default geometry and address/twiddle helpers for the FFT memory scheduler.
// Addresses are computed at FFT_AW_MAX bits and truncated by the caller, so AWL must not exceed 16.
package fft_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } fft_state_t;

    localparam int FFT_AWL    = 8;
    localparam int FFT_RD_LAT = 1;
    localparam int FFT_BF_LAT = 3;
    localparam int FFT_N      = 2 ** FFT_AWL;
    localparam int FFT_L      = FFT_RD_LAT + FFT_BF_LAT;
    localparam int FFT_AW_MAX = 16;

    // Top address: insert a zero bit at position s of butterfly index k.
    function automatic logic [FFT_AW_MAX-1:0] fft_top_addr(input logic [FFT_AW_MAX-1:0] k,
                                                           input int s);
        logic [FFT_AW_MAX-1:0] span_mask;
        span_mask = (FFT_AW_MAX'(1) << s) - FFT_AW_MAX'(1);
        return ((k >> s) << (s + 1)) | (k & span_mask);
    endfunction

    function automatic logic [FFT_AW_MAX-1:0] fft_bot_addr(input logic [FFT_AW_MAX-1:0] k,
                                                           input int s);
        return fft_top_addr(k, s) | (FFT_AW_MAX'(1) << s);
    endfunction

    function automatic logic [FFT_AW_MAX-1:0] fft_tw_addr(input logic [FFT_AW_MAX-1:0] k,
                                                          input int s,
                                                          input int awl);
        logic [FFT_AW_MAX-1:0] span_mask;
        span_mask = (FFT_AW_MAX'(1) << s) - FFT_AW_MAX'(1);
        return (k & span_mask) << (awl - 1 - s);
    endfunction

endpackage

// File: rtl/fft_mem_sched_delay_line.sv
// fft_addr_delay_line: fixed-depth shift register of {valid, top, bot} tracking in-flight butterflies.
// The last stage is the write-back due in the current cycle; i_clr drops every pending entry.
module fft_addr_delay_line #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_clr,
    input  logic          i_vld,
    input  logic [AW-1:0] i_top,
    input  logic [AW-1:0] i_bot,
    output logic          o_vld,
    output logic [AW-1:0] o_top,
    output logic [AW-1:0] o_bot,
    output logic          o_any_vld
);

    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]    r_top [DEPTH];
    logic [AW-1:0]    r_bot [DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vld <= '0;
        end else if (i_clr) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_vld;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // NOTE: only the valid bits are reset; address fields are never consumed while their valid bit is 0.
    always_ff @(posedge CLK) begin
        r_top[0] <= i_top;
        r_bot[0] <= i_bot;
        for (int i = 1; i < DEPTH; i++) begin
            r_top[i] <= r_top[i-1];
            r_bot[i] <= r_bot[i-1];
        end
    end

    assign o_vld     = r_vld[DEPTH-1];
    assign o_top     = r_top[DEPTH-1];
    assign o_bot     = r_bot[DEPTH-1];
    assign o_any_vld = |r_vld;

endmodule

// File: rtl/fft_mem_sched.sv
// In-place radix-2 FFT RAM scheduler: issues butterfly reads and write-backs across all stages.
// Optional FFT_SCHED_ABORT_EN adds i_ABORT, which drops the transform and pending write-backs.
module fft_mem_sched
    import fft_pkg::*;
#(
    parameter int AWL    = FFT_AWL,
    parameter int RD_LAT = FFT_RD_LAT,
    parameter int BF_LAT = FFT_BF_LAT
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           i_START,
    output logic           o_BUSY,
    output logic           o_DONE,
    output logic           o_EN,
    output logic           o_WrE,
    output logic [AWL-1:0] o_ADDR_A,
    output logic [AWL-1:0] o_ADDR_B,
    output logic           o_RD_VLD,
    output logic [AWL-2:0] o_TW_ADDR
`ifdef FFT_SCHED_ABORT_EN
    ,
    input  logic           i_ABORT
`endif
);

    localparam int N   = 2 ** AWL;
    localparam int L   = RD_LAT + BF_LAT;
    localparam int KW  = AWL - 1;
    localparam int TWW = AWL - 1;
    localparam int SW  = (AWL > 2) ? $clog2(AWL) : 1;

    fft_state_t     r_state, w_state_nxt;
    logic [SW-1:0]  r_s, w_s_nxt;
    logic [KW-1:0]  r_k, w_k_nxt;

    logic           r_busy, r_done, r_en, r_wre, r_rd_vld;
    logic [AWL-1:0] r_addr_a, r_addr_b;
    logic [TWW-1:0] r_tw;
    logic           w_busy_nxt, w_done_nxt, w_en_nxt, w_wre_nxt, w_rd_vld_nxt;
    logic [AWL-1:0] w_addr_a_nxt, w_addr_b_nxt;
    logic [TWW-1:0] w_tw_nxt;

    logic           w_abort, w_wb_due, w_drain_done, w_last_stage, w_rd_issue, w_rd_last;
    logic [SW-1:0]  w_rd_s;
    logic [KW-1:0]  w_rd_k;
    logic [AWL-1:0] w_rd_top, w_rd_bot, w_dl_top, w_dl_bot;
    logic [TWW-1:0] w_rd_tw;
    logic           w_dl_vld, w_dl_any;

`ifdef FFT_SCHED_ABORT_EN
    assign w_abort = i_ABORT && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // A due write-back always wins the ports; reads only fill otherwise idle cycles.
    assign w_wb_due     = w_dl_vld && !w_abort;
    assign w_drain_done = (r_state == S_DRAIN) && !w_dl_any;
    assign w_last_stage = (r_s == SW'(AWL - 1));
    assign w_rd_issue   = !w_abort && !w_wb_due &&
                          (((r_state == S_IDLE) && i_START) ||
                           (r_state == S_RUN) ||
                           (w_drain_done && !w_last_stage));

    assign w_rd_s    = (r_state == S_DRAIN) ? r_s + SW'(1) :
                       (r_state == S_RUN)   ? r_s : '0;
    assign w_rd_k    = (r_state == S_RUN) ? r_k : '0;
    assign w_rd_last = (w_rd_k == KW'(N / 2 - 1));
    assign w_rd_top  = AWL'(fft_top_addr(FFT_AW_MAX'(w_rd_k), int'(w_rd_s)));
    assign w_rd_bot  = AWL'(fft_bot_addr(FFT_AW_MAX'(w_rd_k), int'(w_rd_s)));
    assign w_rd_tw   = TWW'(fft_tw_addr(FFT_AW_MAX'(w_rd_k), int'(w_rd_s), AWL));

    fft_addr_delay_line #(
        .DEPTH (L),
        .AW    (AWL)
    ) u_delay_line (
        .CLK       (CLK),
        .RST       (RST),
        .i_clr     (w_abort),
        .i_vld     (w_rd_issue),
        .i_top     (w_rd_top),
        .i_bot     (w_rd_bot),
        .o_vld     (w_dl_vld),
        .o_top     (w_dl_top),
        .o_bot     (w_dl_bot),
        .o_any_vld (w_dl_any)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_s      <= '0;
            r_k      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_en     <= 1'b0;
            r_wre    <= 1'b0;
            r_rd_vld <= 1'b0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_tw     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_s      <= w_s_nxt;
            r_k      <= w_k_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_en     <= w_en_nxt;
            r_wre    <= w_wre_nxt;
            r_rd_vld <= w_rd_vld_nxt;
            r_addr_a <= w_addr_a_nxt;
            r_addr_b <= w_addr_b_nxt;
            r_tw     <= w_tw_nxt;
        end
    end

    // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_k_nxt     = r_k;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else if (w_rd_issue) begin
            w_s_nxt     = w_rd_s;
            w_k_nxt     = w_rd_k + KW'(1);
            w_state_nxt = w_rd_last ? S_DRAIN : S_RUN;
        end else begin
            case (r_state)
                S_DRAIN: if (w_drain_done) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_en_nxt     = w_wb_due || w_rd_issue;
        w_wre_nxt    = w_wb_due;
        w_rd_vld_nxt = w_rd_issue;
        w_addr_a_nxt = r_addr_a;
        w_addr_b_nxt = r_addr_b;
        w_tw_nxt     = r_tw;
        if (w_wb_due) begin
            w_addr_a_nxt = w_dl_top;
            w_addr_b_nxt = w_dl_bot;
        end else if (w_rd_issue) begin
            w_addr_a_nxt = w_rd_top;
            w_addr_b_nxt = w_rd_bot;
            w_tw_nxt     = w_rd_tw;
        end
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    assign o_BUSY    = r_busy;
    assign o_DONE    = r_done;
    assign o_EN      = r_en;
    assign o_WrE     = r_wre;
    assign o_RD_VLD  = r_rd_vld;
    assign o_ADDR_A  = r_addr_a;
    assign o_ADDR_B  = r_addr_b;
    assign o_TW_ADDR = r_tw;

endmodule

// File: tb/tb_fft_mem_sched.sv
// Directed bench for fft_mem_sched: an AWL=3 instance with hand-computed schedules and an AWL=5 instance
// checked for read/write exclusivity, write-back latency and the in-place stage hazard.
module tb_fft_mem_sched;
    import fft_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic       start3, start5;
    logic       busy3, done3, en3, wre3, rdv3;
    logic [2:0] a3, b3;
    logic [1:0] tw3;
    logic       busy5, done5, en5, wre5, rdv5;
    logic [4:0] a5, b5;
    logic [3:0] tw5;
`ifdef FFT_SCHED_ABORT_EN
    logic       abort3, abort5;
`endif

    fft_mem_sched #(.AWL(3), .RD_LAT(1), .BF_LAT(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .i_START(start3), .o_BUSY(busy3), .o_DONE(done3),
        .o_EN(en3), .o_WrE(wre3), .o_ADDR_A(a3), .o_ADDR_B(b3), .o_RD_VLD(rdv3), .o_TW_ADDR(tw3)
`ifdef FFT_SCHED_ABORT_EN
        , .i_ABORT(abort3)
`endif
    );

    fft_mem_sched #(.AWL(5), .RD_LAT(FFT_RD_LAT), .BF_LAT(FFT_BF_LAT)) u_dut5 (
        .CLK(CLK), .RST(RST), .i_START(start5), .o_BUSY(busy5), .o_DONE(done5),
        .o_EN(en5), .o_WrE(wre5), .o_ADDR_A(a5), .o_ADDR_B(b5), .o_RD_VLD(rdv5), .o_TW_ADDR(tw5)
`ifdef FFT_SCHED_ABORT_EN
        , .i_ABORT(abort5)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Hand-derived AWL=3 schedule, indexed [stage][k].
    int exp_top3 [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int exp_bot3 [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int exp_tw3  [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    typedef struct {
        int cyc;
        int top;
        int bot;
    } rd_rec_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic string tg(input int run, input int c, input string name);
        return $sformatf("r%0d c%0d %s", run, c, name);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle3(input string tag);
        check({tag, " en"},   en3,   0);
        check({tag, " wre"},  wre3,  0);
        check({tag, " rdv"},  rdv3,  0);
        check({tag, " busy"}, busy3, 0);
        check({tag, " done"}, done3, 0);
        check({tag, " a"},    a3,    0);
        check({tag, " b"},    b3,    0);
        check({tag, " tw"},   tw3,   0);
    endtask

    // Full AWL=3 transform: start driven in cycle 0, checks cycles 1..26, extra start pulses at p1/p2.
    task automatic run3(input int run, input int p1, input int p2);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            int st;
            int j;
            int kk;
            st = (c - 1) / 8;
            j  = (c - 1) % 8;
            kk = j % 4;
            if (c <= 24) begin
                check(tg(run, c, "en"),   en3,   1);
                check(tg(run, c, "rdv"),  rdv3,  j < 4);
                check(tg(run, c, "wre"),  wre3,  j >= 4);
                check(tg(run, c, "a"),    a3,    exp_top3[st][kk]);
                check(tg(run, c, "b"),    b3,    exp_bot3[st][kk]);
                if (j < 4) check(tg(run, c, "tw"), tw3, exp_tw3[st][kk]);
                check(tg(run, c, "busy"), busy3, 1);
                check(tg(run, c, "done"), done3, 0);
            end else begin
                check(tg(run, c, "en"),   en3,   0);
                check(tg(run, c, "rdv"),  rdv3,  0);
                check(tg(run, c, "wre"),  wre3,  0);
                check(tg(run, c, "busy"), busy3, c == 25);
                check(tg(run, c, "done"), done3, c == 25);
            end
            start3 = (c == p1) || (c == p2);
            if (c < 26) tick();
        end
        start3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_rec_t rdq [$];
        rd_rec_t e;
        int      last_wr_stage [32];
        int      rd_cnt;
        int      wr_cnt;
        int      s;
        int      k;
        int      mask;
        int      etop;
        bit      done_seen;

        RST    = 1'b1;
        start3 = 1'b0;
        start5 = 1'b0;
`ifdef FFT_SCHED_ABORT_EN
        abort3 = 1'b0;
        abort5 = 1'b0;
`endif
        tick();
        tick();
        check_idle3("reset");
        check("reset busy5", busy5, 0);
        check("reset en5",   en5,   0);
        RST = 1'b0;
        tick();

        // Two back-to-back transforms; the second starts in the cycle after DONE and sees ignored starts.
        run3(1, 0, 0);
        run3(2, 3, 25);
        tick();
        check("post busy", busy3, 0);
        check("post en",   en3,   0);
        tick();
        check("post2 busy", busy3, 0);
        check("post2 en",   en3,   0);

        // Asynchronous reset in the middle of stage 1.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (9) tick();
        check("pre_rst en", en3, 1);
        #2 RST = 1'b1;
        #1 check_idle3("rst_async");
        tick();
        tick();
        check_idle3("rst_hold");
        RST = 1'b0;
        repeat (3) tick();
        check("rst_rel busy", busy3, 0);
        check("rst_rel en",   en3,   0);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("rst_new c1 rdv", rdv3, 1);
        check("rst_new c1 a",   a3,   0);
        check("rst_new c1 b",   b3,   1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check($sformatf("rst_new c%0d wre", c), wre3, 0);
        end
        tick();
        check("rst_new c5 wre", wre3, 1);
        check("rst_new c5 a",   a3,   0);
        check("rst_new c5 b",   b3,   1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();

`ifdef FFT_SCHED_ABORT_EN
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (5) tick();
        check("abort c6 wre", wre3, 1);
        abort3 = 1'b1;
        tick();
        abort3 = 1'b0;
        check("abort c7 wre",  wre3,  0);
        check("abort c7 en",   en3,   0);
        check("abort c7 busy", busy3, 0);
        for (int c = 8; c <= 37; c++) begin
            tick();
            check($sformatf("abort c%0d done", c), done3, 0);
            check($sformatf("abort c%0d wre", c),  wre3,  0);
        end
`endif

        // AWL=5, L=4: scoreboard of reads against write-backs.
        for (int i = 0; i < 32; i++) last_wr_stage[i] = -1;
        rd_cnt    = 0;
        wr_cnt    = 0;
        done_seen = 1'b0;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        for (int c = 1; c <= 400 && !done_seen; c++) begin
            check($sformatf("u5 c%0d rd_wr_excl", c), rdv5 & wre5, 0);
            if (rdv5) begin
                s    = rd_cnt / 16;
                k    = rd_cnt % 16;
                mask = (1 << s) - 1;
                etop = ((k & ~mask) << 1) | (k & mask);
                check($sformatf("u5 rd%0d top", rd_cnt), a5,  etop & 31);
                check($sformatf("u5 rd%0d bot", rd_cnt), b5,  (etop | (1 << s)) & 31);
                check($sformatf("u5 rd%0d tw", rd_cnt),  tw5, ((k & mask) << (4 - s)) & 15);
                if (s > 0) begin
                    check($sformatf("u5 rd%0d hazard_a", rd_cnt), last_wr_stage[a5], s - 1);
                    check($sformatf("u5 rd%0d hazard_b", rd_cnt), last_wr_stage[b5], s - 1);
                end
                rdq.push_back('{cyc: c, top: int'(a5), bot: int'(b5)});
                rd_cnt++;
            end else if (wre5) begin
                check($sformatf("u5 wr%0d pending", wr_cnt), rdq.size() > 0, 1);
                if (rdq.size() > 0) begin
                    e = rdq.pop_front();
                    check($sformatf("u5 wr%0d latency", wr_cnt), c - e.cyc, FFT_L);
                    check($sformatf("u5 wr%0d top", wr_cnt), a5, e.top);
                    check($sformatf("u5 wr%0d bot", wr_cnt), b5, e.bot);
                end
                last_wr_stage[a5] = wr_cnt / 16;
                last_wr_stage[b5] = wr_cnt / 16;
                wr_cnt++;
            end
            if (done5) begin
                check("u5 done cycle", c, 161);
                done_seen = 1'b1;
            end
            tick();
        end
        check("u5 done seen", done_seen, 1);
        check("u5 reads",  rd_cnt, 80);
        check("u5 writes", wr_cnt, 80);
        check("u5 idle busy", busy5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_mem_sched.md
# fft_mem_sched

Scheduler for the iterative radix-2 FFT working memory: drives both ports of the in-place dual-port data RAM through all log2(N) stages of a transform. Each cycle it issues either a butterfly read pair or a write-back pair. It generates stage and butterfly indices, top/bottom addresses and twiddle indices, and tracks in-flight butterflies through a fixed-latency delay line. It sits between the FFT top-level control (start/done) and the RAM plus butterfly datapath. It drives no data, only control.

## Interface
- AWL, 8: log2(N); RAM address width.
- RD_LAT, 1: RAM read latency in cycles (1 = low-latency RAM, 2 = output-registered RAM).
- BF_LAT, 3: butterfly datapath latency in cycles, from RAM read data to result ready.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- i_START  in  1  start a transform; sampled only in IDLE.
- o_BUSY  out  1  high from the cycle after accepted start until DONE; reset 0.
- o_DONE  out  1  one-cycle pulse after the last write-back of the final stage; reset 0.
- o_EN  out  1  enable for RAM ports A and B; reset 0.
- o_WrE  out  1  write enable for both ports; 1 = write-back, 0 = read; reset 0.
- o_ADDR_A  out  AWL  top address; reset 0.
- o_ADDR_B  out  AWL  bottom address; reset 0.
- o_RD_VLD  out  1  a butterfly read was issued this cycle; reset 0.
- o_TW_ADDR  out  AWL-1  twiddle index, aligned with o_RD_VLD; reset 0.
- i_ABORT  in  1  present only with FFT_SCHED_ABORT_EN.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
  - IDLE goes to RUN on i_START; stage s = 0 and butterfly k = 0.
  - RUN goes to DRAIN after the read for k = N/2-1 is issued.
  - DRAIN waits until no butterfly is in flight. It then goes to RUN with s+1 and k = 0, or to DONE if s = AWL-1.
  - DONE lasts one cycle, then returns to IDLE.
- Address generation, with span = 2^s:
  - top = ((k >> s) << (s+1)) | (k & (span-1)).
  - bot = top | span.
  - tw = (k & (span-1)) << (AWL-1-s).
  - All arithmetic is unsigned and truncated to port width.
- Delay line: L = RD_LAT + BF_LAT entries of {valid, top, bot}. Every issued read enters it. The entry leaving it is a write-back due that cycle.
- Arbitration:
  - A due write-back always wins. It drives o_EN=1, o_WrE=1 and the stored addresses; k does not advance.
  - Otherwise, in RUN, a read is issued: o_EN=1, o_WrE=0, o_RD_VLD=1, k increments.
  - Every write-back therefore lands exactly L cycles after its read.
- No read of stage s+1 is issued in the same cycle as, or before, the last write-back of stage s. This holds the in-place hazard.
- i_START is ignored while o_BUSY=1.

## Timing
- All outputs are registered and held at reset values while RST=1.
- Start accepted at cycle 0: o_BUSY=1 and the first read are both at cycle 1.
- Read data is valid at the RAM RD_LAT cycles after o_RD_VLD. The datapath must present results exactly BF_LAT cycles later.
- Stage length is N/2 reads plus N/2 writes plus drain bubbles. When N/2 ≤ L it equals N/2 + L cycles.
- The cycle after the DONE pulse is IDLE. A start in that cycle is accepted.
- RST mid-transform clears the state and delay line immediately. Pending write-backs are lost, and RAM contents are undefined for the transform.

## Configuration
- FFT_SCHED_ABORT_EN defined:
  - i_ABORT exists.
  - i_ABORT=1 in any non-IDLE state forces IDLE on the next edge and clears all delay-line valid bits, so pending write-backs are suppressed.
  - o_BUSY=0 next cycle; no o_DONE pulse.
  - Abort outranks a simultaneous write-back.
- FFT_SCHED_ABORT_EN undefined: the port is absent and the only exit from a transform is completion or RST.

## Structure
- Shared package fft_pkg holds:
  - the state enum;
  - localparams N = 2**AWL and L = RD_LAT + BF_LAT;
  - address/twiddle functions, also used by the bench model.
- One sub-module, fft_addr_delay_line: a parameterized shift register of {valid, top, bot}, with synchronous clear for abort.

## Test plan
- Reset values: assert RST mid-transform. All outputs go to 0 asynchronously, and the block sits in IDLE after release.
- AWL=3, RD_LAT=1, BF_LAT=3, start at cycle 0:
  - stage 0 reads (0,1),(2,3),(4,5),(6,7) at cycles 1–4, with writes to the same pairs at cycles 5–8;
  - o_DONE pulses at cycle 25.
- AWL=3 addressing: stage 1 k=1 gives top=1, bot=3, tw=2. Stage 2 k=3 gives top=3, bot=7, tw=3.
- AWL=5, L=4: no cycle has both a read and a write. Every write follows its read by exactly 4 cycles. No stage-(s+1) address is read before its stage-s write.
- i_START pulsed while busy is ignored. A start on the cycle after DONE begins a new transform.
- With FFT_SCHED_ABORT_EN: abort at cycle 6 of the AWL=3 run gives o_WrE=0 from cycle 7, o_BUSY=0 at cycle 7, and no o_DONE.
